booth_seq_mult_ctrl: RTL and testbench

- Sequential radix-4 Booth multiply controller that sequences the Booth partial-product selection over one multiplier recoding group per cycle.
- Accepts a signed multiplicand/multiplier pair through a valid/ready handshake.
- Walks the multiplier in overlapping 3-bit Booth groups and accumulates the shifted partial products into a 2*WIDTH-bit signed product.
- Sits between the operand source and the FMAC adder stage and replaces the fully parallel four-decoder array when area matters.

---
 rtl/booth_seq_mult_ctrl.sv | 119 +++++++++++
 tb/tb_booth_seq_mult_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: one 3-bit recoding group per RUN cycle.
// Optional macro BOOTH_SKIP_ZERO_EN ends RUN early once the remaining groups all decode to zero.
module booth_seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [2:0]           action,
  output logic                 busy
);

  localparam int GROUPS = WIDTH / 2;
  localparam int IDXW   = $clog2(GROUPS);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     y_reg;
  logic [WIDTH:0]       rec;
  logic [2*WIDTH-1:0]   acc;
  logic [IDXW-1:0]      idx;

  logic [WIDTH+1:0]     y_ext;
  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH-1:0]   pp_wide;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH:0]       rec_next;
  logic                 last_group;
  logic                 done_next;

  // Partial product is kept at WIDTH+2 bits so -2y of the most negative operand is exact.
  always_comb begin
    y_ext = {{2{y_reg[WIDTH-1]}}, y_reg};
    case (rec[2:0])
      3'b001, 3'b010: pp = y_ext;
      3'b011:         pp = y_ext << 1;
      3'b100:         pp = -(y_ext << 1);
      3'b101, 3'b110: pp = -y_ext;
      default:        pp = '0;
    endcase
    pp_wide    = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    acc_next   = acc + (pp_wide << {idx, 1'b0});
    rec_next   = {{2{rec[WIDTH]}}, rec[WIDTH:2]};
    last_group = (idx == IDXW'(GROUPS - 1));
`ifdef BOOTH_SKIP_ZERO_EN
    done_next  = last_group || (&rec_next) || (~|rec_next);
`else
    done_next  = last_group;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      action    <= 3'b000;
      busy      <= 1'b0;
      y_reg     <= '0;
      rec       <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            y_reg    <= multiplicand;
            rec      <= {multiplier, 1'b0};
            acc      <= '0;
            idx      <= '0;
            action   <= {multiplier[1:0], 1'b0};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          rec <= rec_next;
          idx <= idx + IDXW'(1);
          if (done_next) begin
            product   <= acc_next;
            out_valid <= 1'b1;
            action    <= 3'b000;
            state     <= DONE;
          end else begin
            action <= rec_next[2:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          action    <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl (WIDTH=8); honours BOOTH_SKIP_ZERO_EN when defined.
module tb_booth_seq_mult_ctrl;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;
  logic [2:0]    action;
  logic          busy;

  logic [2*W-1:0] exp_q[$];
  int checks;
  int failures;

  booth_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .action       (action),
    .busy         (busy)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] y, input logic [W-1:0] m);
    logic signed [2*W-1:0] a;
    logic signed [2*W-1:0] b;
    a = $signed(y);
    b = $signed(m);
    return a * b;
  endfunction

  function automatic logic [2:0] ref_group(input logic [W-1:0] m, input int i);
    logic [W:0] r;
    r = {m, 1'b0};
    return r[2*i +: 3];
  endfunction

  function automatic int ref_runs(input logic [W-1:0] m);
`ifdef BOOTH_SKIP_ZERO_EN
    logic signed [W:0] r;
    r = $signed({m, 1'b0});
    for (int i = 0; i < W/2; i++) begin
      r = r >>> 2;
      if ((&r) || (~|r)) return i + 1;
    end
    return W/2;
`else
    return W/2 + 0 * int'(m[0]);
`endif
  endfunction

  // Driver tasks (all called at a negedge, return at a negedge)
  task automatic send(input logic [W-1:0] y, input logic [W-1:0] m);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    in_valid     = 1'b1;
    multiplicand = y;
    multiplier   = m;
    exp_q.push_back(ref_mul(y, m));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(output int runs, output int lat, output logic [3*(W/2)-1:0] acts);
    runs = 0;
    lat  = 0;
    acts = '0;
    while (!out_valid && lat < 40) begin
      if (busy) begin
        if (runs < W/2) acts[3*runs +: 3] = action;
        runs++;
      end
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout out_valid=%b required=1", out_valid);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    logic [2*W-1:0] got;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, action} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL reset_status got=%b required=%b", {in_ready, out_valid, busy, action}, 6'b100000);
    end
    got = product;
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_product got=%h required=0000", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int runs, lat, nexp;
    logic [3*(W/2)-1:0] acts, exp_acts;
    logic [2*W-1:0] exp;
    logic [W-1:0] m;
    m = 8'd3;
    out_ready = 1'b1;
    send(8'd7, m);
    collect(runs, lat, acts);
    nexp = ref_runs(m);
    exp_acts = '0;
    for (int i = 0; i < nexp; i++) exp_acts[3*i +: 3] = ref_group(m, i);
    checks++;
    if (lat !== nexp) begin
      failures++;
      $display("FAIL basic_latency got=%0d required=%0d", lat, nexp);
    end
    checks++;
    if (acts !== exp_acts) begin
      failures++;
      $display("FAIL basic_actions got=%h required=%h", acts, exp_acts);
    end
    exp = exp_q.pop_front();
    checks++;
    if (product !== exp) begin
      failures++;
      $display("FAIL basic_product got=%h required=%h", product, exp);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, action} !== {1'b0, 1'b1, 3'b000}) begin
      failures++;
      $display("FAIL basic_single_valid got=%b required=%b", {out_valid, in_ready, action}, 5'b01000);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_boundary();
    logic [W-1:0] ys[4] = '{8'h80, 8'h80, 8'h7F, 8'h7F};
    logic [W-1:0] ms[4] = '{8'h80, 8'h7F, 8'h7F, 8'h80};
    int runs, lat;
    logic [3*(W/2)-1:0] acts;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(ys[i], ms[i]);
      collect(runs, lat, acts);
      exp = exp_q.pop_front();
      checks++;
      if (product !== exp) begin
        failures++;
        $display("FAIL boundary_product[%0d] got=%h required=%h", i, product, exp);
      end
      release_out();
    end
  endtask

  task automatic test_zero_skip();
    logic [W-1:0] ms[4] = '{8'h00, 8'hFF, 8'h01, 8'h40};
    int runs, lat;
    logic [3*(W/2)-1:0] acts;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(8'h55, ms[i]);
      collect(runs, lat, acts);
      checks++;
      if (runs !== ref_runs(ms[i])) begin
        failures++;
        $display("FAIL skip_runs[%0d] got=%0d required=%0d", i, runs, ref_runs(ms[i]));
      end
      exp = exp_q.pop_front();
      checks++;
      if (product !== exp) begin
        failures++;
        $display("FAIL skip_product[%0d] got=%h required=%h", i, product, exp);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int runs, lat;
    logic [3*(W/2)-1:0] acts;
    logic [2*W-1:0] exp;
    send(8'hFB, 8'd9);
    collect(runs, lat, acts);
    exp = exp_q[0];
    in_valid = 1'b1;
    multiplicand = 8'd1;
    multiplier = 8'd1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || product !== exp) begin
        failures++;
        $display("FAIL hold[%0d] valid_ready=%b product=%h required=10 %h", i, {out_valid, in_ready}, product, exp);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (product !== exp) begin
      failures++;
      $display("FAIL hold_product got=%h required=%h", product, exp);
    end
    release_out();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL hold_release got=%b required=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset_mid_run();
    int runs, lat;
    logic [3*(W/2)-1:0] acts;
    logic [2*W-1:0] exp;
    send(8'h21, 8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    checks++;
    if ({in_ready, out_valid, busy, action} !== 6'b100000 || product !== '0) begin
      failures++;
      $display("FAIL midrun_reset status=%b product=%h required=100000 0000", {in_ready, out_valid, busy, action}, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL midrun_no_output got=%b required=00", {out_valid, busy});
    end
    send(8'd12, 8'hF4);
    collect(runs, lat, acts);
    exp = exp_q.pop_front();
    checks++;
    if (product !== exp) begin
      failures++;
      $display("FAIL midrun_next_product got=%h required=%h", product, exp);
    end
    release_out();
  endtask

  task automatic test_random();
    int runs, lat, n;
    logic [3*(W/2)-1:0] acts;
    logic [2*W-1:0] exp;
    logic [W-1:0] y, m;
    for (int k = 0; k < 1000; k++) begin
      y = W'($urandom_range(0, 255));
      m = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(y, m);
      collect(runs, lat, acts);
      checks++;
      if (runs !== ref_runs(m)) begin
        failures++;
        $display("FAIL rand_runs[%0d] got=%0d required=%0d", k, runs, ref_runs(m));
      end
      n = 0;
      while (1) begin
        out_ready = (n >= 15) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_ready) break;
        @(negedge clk);
        n++;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (!out_valid || product !== exp) begin
        failures++;
        $display("FAIL rand_product[%0d] valid=%b got=%h required=%h", k, out_valid, product, exp);
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_duplicate[%0d] out_valid=%b required=0", k, out_valid);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_leftover got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundary();
    test_zero_skip();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
